// File: rtl/floor_req_sched_pkg.sv
// floor_req_pkg: shared types and helpers for the floor request scheduler.
//   state_t      - scheduler FSM states
//   NUM_FLOORS   - default floor count
//   MAX_FLOORS   - width used by the mask helpers (callers zero-extend)
//   is_onehot    - exactly one bit set
//   lowest_above - one-hot of the lowest pending bit above the one-hot position
//   highest_below- one-hot of the highest pending bit below the one-hot position
package floor_req_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int MAX_FLOORS = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DWELL     = 2'd3
    } state_t;

    function automatic logic is_onehot(input logic [MAX_FLOORS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Scan upward from bit 0; the first pending bit seen after passing the
    // position bit is the nearest floor above.
    function automatic logic [MAX_FLOORS-1:0] lowest_above(
        input logic [MAX_FLOORS-1:0] pend,
        input logic [MAX_FLOORS-1:0] pos
    );
        logic [MAX_FLOORS-1:0] res;
        logic passed;
        logic found;
        res    = '0;
        passed = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (passed && pend[i] && !found) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end
            if (pos[i]) passed = 1'b1;
        end
        return res;
    endfunction

    // Mirror of lowest_above, scanning downward from the top bit.
    function automatic logic [MAX_FLOORS-1:0] highest_below(
        input logic [MAX_FLOORS-1:0] pend,
        input logic [MAX_FLOORS-1:0] pos
    );
        logic [MAX_FLOORS-1:0] res;
        logic passed;
        logic found;
        res    = '0;
        passed = 1'b0;
        found  = 1'b0;
        for (int i = MAX_FLOORS - 1; i >= 0; i--) begin
            if (passed && pend[i] && !found) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end
            if (pos[i]) passed = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/floor_req_sched_if.sv
// floor_req_sched_if: signal bundle between the scheduler and its environment.
//   btn_req   - raw floor-call buttons (asynchronous levels)
//   cur_floor - one-hot elevator position
//   req_floor - one-hot target floor
//   pending   - outstanding requests
//   door_open - high during the dwell window
//   dir_up    - current/last travel direction, 1 = up
//   state     - scheduler FSM state, exposed for observation
// modport master: the scheduler side; modport slave: the environment side.
// None of these signals form a valid/ready handshake: inputs are levels
// sampled every clock, outputs are registered levels valid every cycle.
interface floor_req_sched_if #(
    parameter int NUM_FLOORS = floor_req_pkg::NUM_FLOORS
);
    import floor_req_pkg::*;

    logic [NUM_FLOORS-1:0] btn_req;
    logic [NUM_FLOORS-1:0] cur_floor;
    logic [NUM_FLOORS-1:0] req_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  door_open;
    logic                  dir_up;
    state_t                state;

    modport master (
        input  btn_req, cur_floor,
        output req_floor, pending, door_open, dir_up, state
    );

    modport slave (
        output btn_req, cur_floor,
        input  req_floor, pending, door_open, dir_up, state
    );

endinterface

// File: rtl/floor_req_sched_btn_sync_deb.sv
// btn_sync_deb: one floor button. Two-flop synchronizer, optional debounce,
// and rising-edge detect producing a single-cycle pulse.
//   clk, rst - clock, asynchronous active-high reset
//   btn      - raw asynchronous button level
//   pulse    - one-cycle pulse on a qualified press
// FLOOR_REQ_DEBOUNCE_EN: when defined, the synchronized level must stay high
// for DEB_CYCLES consecutive cycles before it counts as pressed.
module btn_sync_deb
`ifdef FLOOR_REQ_DEBOUNCE_EN
#(
    parameter int DEB_CYCLES = 4
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync_1;
    logic sync_2;
    logic level;
    logic level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

`ifdef FLOOR_REQ_DEBOUNCE_EN
    localparam int DCW = $clog2(DEB_CYCLES + 1);
    logic [DCW-1:0] deb_cnt;

    // Saturating run-length of the synchronized level; any low sample restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt <= '0;
        end else if (!sync_2) begin
            deb_cnt <= '0;
        end else if (deb_cnt != DCW'(DEB_CYCLES)) begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign level = (deb_cnt == DCW'(DEB_CYCLES));
`else
    assign level = sync_2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_d <= 1'b0;
        else     level_d <= level;
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/floor_req_sched.sv
// floor_req_sched: captures floor calls and picks the next target with a
// SCAN policy, drives the one-hot target, and generates the door dwell.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - floor_req_sched_if.master (btn_req, cur_floor in;
//              req_floor, pending, door_open, dir_up, state out)
// FLOOR_REQ_DEBOUNCE_EN: enables per-button debounce (DEB_CYCLES).
module floor_req_sched
    import floor_req_pkg::*;
#(
    parameter int NUM_FLOORS   = floor_req_pkg::NUM_FLOORS,
    parameter int DWELL_CYCLES = 16
`ifdef FLOOR_REQ_DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES   = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    floor_req_sched_if.master     bus
);

    localparam int CW = $clog2(DWELL_CYCLES + 1);
    typedef logic [NUM_FLOORS-1:0] vec_t;

    vec_t           pulse, cur, hit, tgt_up, tgt_dn, clr;
    vec_t           pend_q, req_q;
    state_t         state_q;
    logic           door_q, dir_q;
    logic [CW-1:0]  cnt_q;
    logic           cur_ok, any_up, any_dn, arrive, reload;

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
        btn_sync_deb
`ifdef FLOOR_REQ_DEBOUNCE_EN
            #(.DEB_CYCLES(DEB_CYCLES))
`endif
            u_btn (
                .clk   (clk),
                .rst   (rst),
                .btn   (bus.btn_req[g]),
                .pulse (pulse[g])
            );
    end

    assign cur    = bus.cur_floor;
    assign cur_ok = is_onehot(MAX_FLOORS'(cur));
    assign hit    = pend_q & cur;
    assign tgt_up = NUM_FLOORS'(lowest_above(MAX_FLOORS'(pend_q), MAX_FLOORS'(cur)));
    assign tgt_dn = NUM_FLOORS'(highest_below(MAX_FLOORS'(pend_q), MAX_FLOORS'(cur)));
    assign any_up = |tgt_up;
    assign any_dn = |tgt_dn;

    // Arrival at any pending floor stops the car, not only the chosen target.
    assign arrive = cur_ok && (state_q != DWELL) && (|hit);
    // A press for the floor being served restarts the door window instead of latching.
    assign reload = cur_ok && (state_q == DWELL) && (|(pulse & req_q));

    // In DWELL req_q equals the served floor even if cur_floor glitches.
    always_comb begin
        clr = '0;
        if (arrive)                clr = cur;
        else if (state_q == DWELL) clr = req_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= '0;
        else     pend_q <= (pend_q | pulse) & ~clr;
    end

    // Outputs are registered alongside the state, so they change on the
    // same edge as the transition. A non-one-hot position freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= vec_t'(1);
            door_q  <= 1'b0;
            dir_q   <= 1'b1;
            cnt_q   <= '0;
        end else if (cur_ok) begin
            if (arrive) begin
                state_q <= DWELL;
                req_q   <= cur;
                door_q  <= 1'b1;
                cnt_q   <= CW'(DWELL_CYCLES);
            end else begin
                case (state_q)
                    IDLE: begin
                        if (any_up) begin
                            state_q <= MOVE_UP;
                            req_q   <= tgt_up;
                            dir_q   <= 1'b1;
                        end else if (any_dn) begin
                            state_q <= MOVE_DOWN;
                            req_q   <= tgt_dn;
                            dir_q   <= 1'b0;
                        end else begin
                            req_q   <= cur;
                        end
                    end
                    MOVE_UP: begin
                        if (any_up) begin
                            req_q   <= tgt_up;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= cur;
                        end
                    end
                    MOVE_DOWN: begin
                        if (any_dn) begin
                            req_q   <= tgt_dn;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= cur;
                        end
                    end
                    DWELL: begin
                        if (reload) begin
                            cnt_q <= CW'(DWELL_CYCLES);
                        end else if (cnt_q <= CW'(1)) begin
                            door_q <= 1'b0;
                            cnt_q  <= '0;
                            if ((dir_q && any_up) || (!dir_q && !any_dn && any_up)) begin
                                state_q <= MOVE_UP;
                                req_q   <= tgt_up;
                                dir_q   <= 1'b1;
                            end else if (any_dn) begin
                                state_q <= MOVE_DOWN;
                                req_q   <= tgt_dn;
                                dir_q   <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                req_q   <= cur;
                            end
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.req_floor = req_q;
    assign bus.pending   = pend_q;
    assign bus.door_open = door_q;
    assign bus.dir_up    = dir_q;
    assign bus.state     = state_q;

endmodule

// File: doc/floor_req_sched.md
# floor_req_sched

Request scheduler feeding the 4-floor elevator controller. It captures asynchronous floor-call buttons, holds them as pending requests, and picks the next target floor with a SCAN (continue-in-direction) policy. It drives that target as a one-hot `req_floor` to the elevator and consumes the elevator's one-hot position (`rec_floor`) back as `cur_floor`. It also generates the door-open dwell window and clears each request on arrival.

## Interface
- `NUM_FLOORS`, 4: floor count; one-hot width of all floor vectors.
- `DWELL_CYCLES`, 16: door-open cycles per stop; must be ≥1.
- `DEB_CYCLES`, 4: consecutive stable-high cycles required when debounce is compiled in.
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset; asynchronous and active-high.
- `btn_req`, in, NUM_FLOORS: raw level button inputs, bit i = floor i, asynchronous to `clk`.
- `cur_floor`, in, NUM_FLOORS: one-hot elevator position, driven from elevator `rec_floor`.
- `req_floor`, out, NUM_FLOORS: registered one-hot target, driven to elevator `req_floor`.
- `pending`, out, NUM_FLOORS: registered outstanding requests.
- `door_open`, out, 1: registered; high during dwell.
- `dir_up`, out, 1: registered; current/last travel direction, 1 = up.

## Operation
- Reset values: `req_floor`=0001, `pending`=0, `door_open`=0, `dir_up`=1, state IDLE, dwell counter 0. Reset mid-operation drops all pending requests immediately.
- Capture:
  - Each `btn_req` bit passes through a 2-flop synchronizer and a rising-edge detector.
  - An edge sets the corresponding `pending` bit. Holding a button does not re-trigger.
  - A press on an already-pending floor has no effect.
- Floor order: bit index equals floor number. One-hot numeric order therefore matches floor order.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, DWELL.
  - **IDLE**: `req_floor`=`cur_floor`.
    - `pending & cur_floor` ≠ 0 → DWELL.
    - Else any pending above → MOVE_UP, with `dir_up`=1.
    - Else any pending below → MOVE_DOWN, with `dir_up`=0.
    - Up wins when both are present.
  - **MOVE_UP**: target = lowest pending bit above `cur_floor`, recomputed every cycle so newly pressed intermediate floors are picked up. `req_floor`=target. When `cur_floor` equals a pending floor → DWELL. If no pending above → IDLE.
  - **MOVE_DOWN**: mirror of MOVE_UP; target = highest pending bit below `cur_floor`.
  - **DWELL**:
    - `door_open`=1 and `req_floor`=`cur_floor`.
    - A new press for `cur_floor` is not latched; it reloads the dwell counter instead.
    - On expiry: pending in `dir_up` direction → continue that direction; else pending in the opposite direction → reverse (toggle `dir_up`); else → IDLE.
- A `cur_floor` value that is not one-hot (including 0):
  - FSM and `req_floor` hold, and the dwell counter freezes.
  - Capture continues.
- Simultaneous press and clear on the same floor in the same cycle: the clear wins.
- Dwell counter width is `$clog2(DWELL_CYCLES+1)`.

## Timing
- `btn_req` rise → `pending` bit set 3 cycles later without debounce (2 sync flops + edge register).
- State change → `req_floor` update on the same clock edge (registered outputs derived from next-state).
- On the arrival edge, the `pending` bit is cleared, `door_open` rises, and state becomes DWELL together.
- `door_open` stays high for exactly `DWELL_CYCLES` cycles unless reloaded. It falls on the edge that leaves DWELL.
- `pending` set → IDLE departure: 1 cycle.

## Configuration
- `FLOOR_REQ_DEBOUNCE_EN` defined:
  - After synchronization, a button must read high for `DEB_CYCLES` consecutive cycles before the edge registers.
  - Capture latency becomes 3+`DEB_CYCLES` cycles.
  - Glitches shorter than that are ignored.
- Not defined: debounce logic is absent and `DEB_CYCLES` is unused.

## Structure
- Package `floor_req_pkg`:
  - state enum typedef (IDLE, MOVE_UP, MOVE_DOWN, DWELL);
  - default `NUM_FLOORS`;
  - functions for the lowest-set-bit-above and highest-set-bit-below masks.
- Sub-module `btn_sync_deb`: one per floor via generate. Contains the synchronizer, optional debounce, and edge detect, and outputs a one-cycle pulse.

## Test plan
- Reset, then IDLE with `cur_floor`=0001 and no presses → `req_floor`=0001, `door_open`=0, `pending`=0 indefinitely.
- Press floor 3 (`btn_req`=1000) from floor 0:
  - `pending`=1000 after 3 cycles;
  - `req_floor`=1000 one cycle later;
  - feed `cur_floor` 0010→0100→1000 → DWELL, `door_open` high 16 cycles, `pending`=0, then IDLE.
- At floor 0, press floors 3 and 1 simultaneously → target 0010 first, dwell, then target 1000.
- At floor 2 moving up toward floor 3, press floor 0 → floor 3 served first, then reverse, `dir_up`=0, target 0001.
- Hold `btn_req`[2] high 50 cycles → `pending` set once. A second press during floor-2 DWELL → not latched; dwell extends to 16 cycles from that press.
- Assert `rst` mid-MOVE_UP with `pending`=1010 → asynchronous clear: `pending`=0, `req_floor`=0001, `door_open`=0. With `FLOOR_REQ_DEBOUNCE_EN`, a 2-cycle pulse on `btn_req` → no `pending` change.
